// File: rtl/mux_nto1_rr_if.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr_if
// Bundle of the N-channel mux handshake and data signals.
//   mode       : 0 = manual select, 1 = round-robin
//   se1        : manual channel select (ignored in round-robin)
//   in_data    : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel data valid
//   in_ready   : per-channel accept (one-hot or zero)
//   out        : registered output data
//   out_ch     : channel index that supplied `out`
//   out_valid  : output register holds data
//   out_ready  : sink accepts `out` this cycle
// Modports: master = sources + sink side, slave = the mux itself.
// ---------------------------------------------------------------------------
interface mux_nto1_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic                    mode;
  logic [SEL_W-1:0]        se1;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mode, se1, in_data, in_valid, out_ready,
    input  in_ready, out, out_ch, out_valid
  );

  modport slave (
    input  mode, se1, in_data, in_valid, out_ready,
    output in_ready, out, out_ch, out_valid
  );
endinterface

// File: rtl/mux_nto1_rr.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on
// every input and a single-entry output register. Channel choice is either
// manual (bus.se1) or a fair round-robin scan starting after the last
// channel served.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mux_nto1_rr_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module mux_nto1_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_nto1_rr_if.slave   bus
);
  localparam int SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0] ptr;        // last channel granted in round-robin mode
  logic             load_en;    // output register can take a word this cycle
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic             transfer;

  // Register is free when empty or being drained by the sink this cycle,
  // which gives bubble-free pass-through at full rate.
  assign load_en  = !bus.out_valid || bus.out_ready;
  assign transfer = grant_vld && load_en && !rst;

  // NOTE: every variable assigned in an always_comb gets a default at the
  // top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    if (!bus.mode) begin
      // Manual: out-of-range selects simply never match a channel.
      for (int i = 0; i < N_CH; i++) begin
        if (bus.se1 == SEL_W'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(i);
        end
      end
    end else begin
      // Round-robin: scan ptr+1, ptr+2, ... wrapping, ending at ptr itself.
      for (int k = 1; k <= N_CH; k++) begin
        idx = (int'(ptr) + k) % N_CH;
        if (!grant_vld && bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_data   = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
      bus.in_ready[i] = transfer && (grant == SEL_W'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      ptr           <= SEL_W'(N_CH - 1);   // channel 0 first after reset
    end else if (transfer) begin
      bus.out       <= grant_data;
      bus.out_ch    <= grant;
      bus.out_valid <= 1'b1;
      if (bus.mode) begin
        ptr <= grant;
      end
    end else if (bus.out_ready) begin
      // Drained with nothing new: data and channel keep their last values.
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_nto1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_rr
// Bench for mux_nto1_rr: a 4-channel instance driven by a directed table and
// random traffic against a behavioural model, plus a 3-channel instance for
// the non-power-of-2 select and wrap cases.
// ---------------------------------------------------------------------------
module tb_mux_nto1_rr;
  logic clk = 1'b0;
  logic rst4, rst3;
  always #5 clk = ~clk;

  mux_nto1_rr_if #(.N_CH(4), .WIDTH(8)) bus4 ();
  mux_nto1_rr_if #(.N_CH(3), .WIDTH(8)) bus3 ();

  mux_nto1_rr #(.N_CH(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  mux_nto1_rr #(.N_CH(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model of the 4-channel instance ----------
  int         m_ptr = 3, m_ch = 0, m_valid = 0;
  logic [7:0] m_out = '0;

  function automatic int ref_grant(input bit mode, input int se1,
                                   input logic [3:0] v, input int ptr);
    if (!mode) return (se1 < 4 && v[se1]) ? se1 : -1;
    for (int k = 1; k <= 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // One cycle on bus4: apply inputs, check in_ready against the model, clock,
  // update model, check the output register. Returns at the next negedge.
  task automatic step4(input bit r, input bit m, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] v, input bit ordy,
                       output logic [3:0] rdy_seen);
    int g;
    logic [3:0] exp_rdy;
    rst4 = r; bus4.mode = m; bus4.se1 = s; bus4.in_data = d;
    bus4.in_valid = v; bus4.out_ready = ordy;
    #1;
    g = ref_grant(m, int'(s), v, m_ptr);
    exp_rdy = (!r && g >= 0 && (m_valid == 0 || ordy)) ? 4'(1 << g) : 4'b0;
    rdy_seen = bus4.in_ready;
    check("in_ready", bus4.in_ready, exp_rdy);
    @(posedge clk); #1;
    if (r) begin
      m_out = '0; m_ch = 0; m_valid = 0; m_ptr = 3;
    end else if (exp_rdy != 0) begin
      m_out = d[g*8 +: 8]; m_ch = g; m_valid = 1;
      if (m) m_ptr = g;
    end else if (ordy) begin
      m_valid = 0;
    end
    check("out", bus4.out, m_out);
    check("out_ch", bus4.out_ch, m_ch);
    check("out_valid", bus4.out_valid, m_valid);
    @(negedge clk);
  endtask

  // One cycle on bus3 with explicit expectations.
  task automatic step3(input bit r, input bit m, input logic [1:0] s, input logic [2:0] v,
                       input logic [2:0] e_rdy, input bit e_vld,
                       input logic [1:0] e_ch, input logic [7:0] e_out);
    rst3 = r; bus3.mode = m; bus3.se1 = s; bus3.in_valid = v; bus3.out_ready = 1'b1;
    #1;
    check("n3_in_ready", bus3.in_ready, e_rdy);
    @(posedge clk); #1;
    check("n3_out_valid", bus3.out_valid, e_vld);
    if (e_vld) begin
      check("n3_out_ch", bus3.out_ch, e_ch);
      check("n3_out", bus3.out, e_out);
    end
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------------------------------
  typedef struct {
    bit         r;
    bit         m;
    logic [1:0] s;
    logic [3:0] v;
    bit         ordy;
    logic [3:0] e_rdy;
    bit         e_vld;
    logic [1:0] e_ch;
    logic [7:0] e_out;
  } vec_t;

  function automatic vec_t mk(bit r, bit m, logic [1:0] s, logic [3:0] v, bit ordy,
                              logic [3:0] e_rdy, bit e_vld, logic [1:0] e_ch,
                              logic [7:0] e_out);
    vec_t t;
    t.r = r; t.m = m; t.s = s; t.v = v; t.ordy = ordy;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_ch = e_ch; t.e_out = e_out;
    return t;
  endfunction

  localparam logic [31:0] DATA4 = {8'h44, 8'hA5, 8'h22, 8'h11};

  initial begin
    vec_t tbl[$];
    logic [3:0] rdy;

    rst3 = 1'b1; bus3.mode = 1'b0; bus3.se1 = '0; bus3.in_valid = '0;
    bus3.out_ready = 1'b1; bus3.in_data = {8'h33, 8'h22, 8'h11};

    //               r  m  se1   valid   ordy e_rdy    vld ch  out
    tbl.push_back(mk(1, 1, 2'd0, 4'hF,   1,   4'b0000, 0, 0, 8'h00)); // reset
    tbl.push_back(mk(1, 1, 2'd0, 4'hF,   1,   4'b0000, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 2'd2, 4'hF,   1,   4'b0100, 1, 2, 8'hA5)); // manual ch2
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b0001, 1, 0, 8'h11)); // rr 0..3,0,1
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b0010, 1, 1, 8'h22));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b0100, 1, 2, 8'hA5));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b1000, 1, 3, 8'h44));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b0001, 1, 0, 8'h11));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b0010, 1, 1, 8'h22));
    tbl.push_back(mk(0, 1, 2'd0, 4'hA,   1,   4'b1000, 1, 3, 8'h44)); // ch1/ch3 only
    tbl.push_back(mk(0, 1, 2'd0, 4'hA,   1,   4'b0010, 1, 1, 8'h22));
    tbl.push_back(mk(0, 1, 2'd0, 4'hA,   1,   4'b1000, 1, 3, 8'h44));
    tbl.push_back(mk(0, 1, 2'd0, 4'hA,   1,   4'b0010, 1, 1, 8'h22));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   0,   4'b0000, 1, 1, 8'h22)); // backpressure
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   0,   4'b0000, 1, 1, 8'h22));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   0,   4'b0000, 1, 1, 8'h22));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b0100, 1, 2, 8'hA5)); // release
    tbl.push_back(mk(0, 1, 2'd0, 4'h0,   1,   4'b0000, 0, 2, 8'hA5)); // drain
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b1000, 1, 3, 8'h44));
    tbl.push_back(mk(1, 1, 2'd0, 4'hF,   1,   4'b0000, 0, 0, 8'h00)); // reset mid-op
    tbl.push_back(mk(0, 1, 2'd0, 4'hF,   1,   4'b0001, 1, 0, 8'h11));
    tbl.push_back(mk(0, 0, 2'd1, 4'hD,   1,   4'b0000, 0, 0, 8'h11)); // se1 not valid
    tbl.push_back(mk(0, 0, 2'd1, 4'hF,   0,   4'b0010, 1, 1, 8'h22)); // empty, !ordy

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step4(tbl[i].r, tbl[i].m, tbl[i].s, DATA4, tbl[i].v, tbl[i].ordy, rdy);
      check($sformatf("tbl%0d_in_ready", i), rdy, tbl[i].e_rdy);
      check($sformatf("tbl%0d_out_valid", i), bus4.out_valid, tbl[i].e_vld);
      check($sformatf("tbl%0d_out_ch", i), bus4.out_ch, tbl[i].e_ch);
      check($sformatf("tbl%0d_out", i), bus4.out, tbl[i].e_out);
    end

    // ---------------- random traffic against the model --------------------
    for (int i = 0; i < 400; i++) begin
      step4($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom, 4'($urandom),
            $urandom_range(0, 3) != 0, rdy);
    end

    // ---------------- 3-channel instance ----------------------------------
    //    r  m  se1   valid   e_rdy   vld ch  out
    step3(1, 0, 2'd0, 3'b111, 3'b000, 0, 0, 8'h00);
    step3(0, 0, 2'd0, 3'b111, 3'b001, 1, 0, 8'h11);
    step3(0, 0, 2'd3, 3'b111, 3'b000, 0, 0, 8'h00); // out-of-range select
    step3(0, 0, 2'd3, 3'b111, 3'b000, 0, 0, 8'h00);
    step3(0, 0, 2'd2, 3'b111, 3'b100, 1, 2, 8'h33);
    step3(0, 1, 2'd3, 3'b111, 3'b001, 1, 0, 8'h11); // rr from ptr=2
    step3(0, 1, 2'd3, 3'b111, 3'b010, 1, 1, 8'h22);
    step3(0, 1, 2'd3, 3'b111, 3'b100, 1, 2, 8'h33);
    step3(0, 1, 2'd3, 3'b111, 3'b001, 1, 0, 8'h11); // wrap 2 -> 0

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
